// File: rtl/bs_pkg.sv
// Shared definitions for the bus generator / arbiter block.
package bs_pkg;

  // Width of the destination ID field at the top of every packet.
  localparam int unsigned ID_W = 8;

  // Destination ID that addresses every driver except the sender.
  localparam logic [ID_W-1:0] BCAST_DEFAULT = 8'hFF;

  // Two-phase transfer: pick a source, then deliver its packet.
  typedef enum logic [0:0] {
    StArb  = 1'b0,
    StDlvr = 1'b1
  } bs_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request selector: searches upward from last_grant_i + 1, wrapping at N.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] last_grant_i,
  output logic [IdxW-1:0] grant_o,
  output logic            valid_o
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    logic [IdxW-1:0] idx;
    idx     = '0;
    grant_o = '0;
    valid_o = 1'b0;
    for (int unsigned i = N; i >= 1; i--) begin
      idx = IdxW'((32'(last_grant_i) + i) % N);
      if (req_i[idx]) begin
        grant_o = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bs_gnrtr_n_rbtr.sv
// Bus generator and arbiter: pops one packet from a round-robin selected driver,
// then delivers it next cycle to one receiver, to all others (broadcast), or drops it.
module bs_gnrtr_n_rbtr
  import bs_pkg::*;
#(
  parameter int unsigned     bits      = 1,
  parameter int unsigned     drvrs     = 4,
  parameter int unsigned     pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = BCAST_DEFAULT
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [bits-1:0][drvrs-1:0]              pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
  output logic [bits-1:0][drvrs-1:0]              pop,
  output logic [bits-1:0][drvrs-1:0]              push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

  localparam int unsigned IdxW = (drvrs > 1) ? $clog2(drvrs) : 1;

  bs_state_e              state_q, state_d;
  logic [IdxW-1:0]        last_grant_q, last_grant_d;
  logic [IdxW-1:0]        source_q, source_d;
  logic [pckg_sz-1:0]     pkt_q, pkt_d;
  logic [drvrs-1:0]       pop_q, pop_d;
  logic [drvrs-1:0]       push_q, push_d;

  logic [IdxW-1:0]        grant;
  logic                   grant_vld;
  logic [ID_W-1:0]        pkt_id;

  assign pkt_id = pkt_q[pckg_sz-1 -: ID_W];

  rr_arbiter #(
    .N    (drvrs),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .req_i        (pndng[0]),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .valid_o      (grant_vld)
  );

  // Next-state: arbitrate and pop in StArb, decode destination and push in StDlvr.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    source_d     = source_q;
    pkt_d        = pkt_q;
    pop_d        = '0;
    push_d       = '0;
    unique case (state_q)
      StArb: begin
        if (grant_vld) begin
          pop_d[grant] = 1'b1;
          pkt_d        = D_pop[0][grant];
          source_d     = grant;
          state_d      = StDlvr;
        end
      end
      StDlvr: begin
        if (pkt_id == broadcast) begin
          push_d           = '1;
          push_d[source_q] = 1'b0;
        end else if (32'(pkt_id) < drvrs) begin
          push_d[pkt_id[IdxW-1:0]] = 1'b1;
        end
        // Out-of-range IDs fall through with no push: the packet is dropped.
        last_grant_d = source_q;
        state_d      = StArb;
      end
    endcase
  end

  // State and registered outputs; reset aborts any in-flight delivery.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StArb;
      last_grant_q <= IdxW'(drvrs - 1);
      source_q     <= '0;
      pkt_q        <= '0;
      pop_q        <= '0;
      push_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      source_q     <= source_d;
      pkt_q        <= pkt_d;
      pop_q        <= pop_d;
      push_q       <= push_d;
    end
  end

  // Only bus 0 is implemented; any further buses are tied off.
  always_comb begin
    pop     = '0;
    push    = '0;
    D_push  = '0;
    pop[0]  = pop_q;
    push[0] = push_q;
    for (int unsigned d = 0; d < drvrs; d++) begin
      D_push[0][d] = pkt_q;
    end
  end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Scoreboard bench: stimulus queues packets and expected pop/push events; a single
// negedge process models the driver FIFOs and matches DUT strobes against the queue.
module tb_bs_gnrtr_n_rbtr;

  localparam int unsigned ND = 8;
  localparam int unsigned PW = 16;

  typedef struct packed {
    logic [2:0]    drv;
    logic [PW-1:0] pkt;
    logic [ND-1:0] pop_m;
    logic          has_push;
    logic [ND-1:0] push_m;
    logic [3:0]    gap;
  } cmd_t;

  typedef struct {
    bit            is_push;
    logic [ND-1:0] mask;
    logic [PW-1:0] data;
    int            gap;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [0:0][ND-1:0]         pndng;
  logic [0:0][ND-1:0][PW-1:0] D_pop;
  logic [0:0][ND-1:0]         pop;
  logic [0:0][ND-1:0]         push;
  logic [0:0][ND-1:0][PW-1:0] D_push;

  cmd_t cmd;
  bit   cmd_vld  = 1'b0;
  bit   done_req = 1'b0;
  bit   done_ack = 1'b0;

  int   vectors     = 0;
  int   miscompares = 0;

  logic [PW-1:0] fq[ND][$];
  exp_t          exp_q[$];

  bs_gnrtr_n_rbtr #(
    .bits      (1),
    .drvrs     (ND),
    .pckg_sz   (PW),
    .broadcast (8'hFF)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pndng  (pndng),
    .D_pop  (D_pop),
    .pop    (pop),
    .push   (push),
    .D_push (D_push)
  );

  always #5 clk = ~clk;

  initial begin
    pndng = '0;
    D_pop = '0;
  end

  // Monitor, scoreboard and driver-FIFO model share one process.
  int cyc = 0;
  int last_pop_cyc = -100;
  bit rst_prev = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_prev) begin
      chk("reset_pop", 128'(pop[0]), 128'(0));
      chk("reset_push", 128'(push[0]), 128'(0));
      chk("reset_dpush", 128'(D_push[0]), 128'(0));
    end
    rst_prev = reset;
    if (pop[0] != 0 && push[0] != 0) chk("pop_push_overlap", 128'(push[0]), 128'(0));
    if (pop[0] != 0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 128'(pop[0]), 128'(0));
      end else begin
        e = exp_q.pop_front();
        chk("pop_event_kind", 128'(e.is_push), 128'(0));
        chk("pop_mask", 128'(pop[0]), 128'(e.mask));
        if (e.gap != 0) chk("pop_spacing", 128'(cyc - last_pop_cyc), 128'(e.gap));
      end
      last_pop_cyc = cyc;
    end
    if (push[0] != 0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_push", 128'(push[0]), 128'(0));
      end else begin
        e = exp_q.pop_front();
        chk("push_event_kind", 128'(e.is_push), 128'(1));
        chk("push_mask", 128'(push[0]), 128'(e.mask));
        chk("push_data", 128'(D_push[0]), {ND{e.data}});
        chk("push_latency", 128'(cyc - last_pop_cyc), 128'(1));
      end
    end
    // FIFO model: a pop strobe seen this cycle consumes the head.
    for (int d = 0; d < ND; d++) begin
      if (pop[0][d] === 1'b1 && fq[d].size() > 0) void'(fq[d].pop_front());
    end
    if (cmd_vld) begin
      fq[cmd.drv].push_back(cmd.pkt);
      exp_q.push_back('{is_push: 1'b0, mask: cmd.pop_m, data: cmd.pkt, gap: int'(cmd.gap)});
      if (cmd.has_push)
        exp_q.push_back('{is_push: 1'b1, mask: cmd.push_m, data: cmd.pkt, gap: 0});
    end
    for (int d = 0; d < ND; d++) begin
      pndng[0][d] = (fq[d].size() != 0);
      D_pop[0][d] = (fq[d].size() != 0) ? fq[d][0] : '0;
    end
    if (done_req && !done_ack) begin
      chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
      done_ack = 1'b1;
    end
  end

  // Called at posedge+1; the command is visible to exactly one negedge.
  task automatic issue(input int drv, input logic [PW-1:0] pkt, input logic [ND-1:0] pop_m,
                       input bit has_push, input logic [ND-1:0] push_m, input int gap);
    cmd     = '{drv: 3'(drv), pkt: pkt, pop_m: pop_m, has_push: has_push,
                push_m: push_m, gap: 4'(gap)};
    cmd_vld = 1'b1;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    logic [7:0] dst;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Unicast: driver 2 -> receiver 5.
    issue(2, 16'h05AB, 8'h04, 1'b1, 8'h20, 0);
    drain();
    // Broadcast from driver 3: everyone but 3.
    issue(3, 16'hFF12, 8'h08, 1'b1, 8'hF7, 0);
    drain();
    // Invalid destination 9: popped then dropped.
    issue(1, 16'h0900, 8'h02, 1'b0, 8'h00, 0);
    drain();
    // Self-delivery.
    issue(4, 16'h04AA, 8'h10, 1'b1, 8'h10, 0);
    drain();

    // Reset raised while in the delivery cycle: the push must never appear.
    issue(6, 16'h02CC, 8'h40, 1'b0, 8'h00, 0);
    n = 0;
    while (pop[0] == 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    drain();

    // All drivers pending, loaded under reset so arbitration starts from driver 0.
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int d = 0; d < ND; d++) begin
        if (k == 0) begin
          dst = 8'((d + 3) % ND);
          issue(d, {dst, 8'(d * 16 + k)}, 8'(1 << d), 1'b1, 8'(1 << ((d + 3) % ND)),
                (d == 0) ? 0 : 2);
        end else begin
          issue(d, {8'hFF, 8'(d * 16 + k)}, 8'(1 << d), 1'b1, ~8'(1 << d), 2);
        end
      end
    end
    reset = 1'b0;
    drain();

    done_req = 1'b1;
    n = 0;
    while (!done_ack && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done_ack) begin
      miscompares++;
      $display("FAIL final_check: got no acknowledgement, expected one");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bs_gnrtr_n_rbtr.md
BS_GNRTR_N_RBTR -- requirements
Module: bs_gnrtr_n_rbtr

Interface
REQ-001 Parameter bits, default 1, number of buses; only 1 is required to be supported.
REQ-002 Parameter drvrs, default 4, number of attached drivers/FIFOs (bench uses 8).
REQ-003 Parameter pckg_sz, default 16, packet width in bits; must be >= 9.
REQ-004 Parameter broadcast, default 8'hFF, destination ID meaning "all drivers".
REQ-005 clk  input  1  rising-edge clock for all logic.
REQ-006 reset  input  1  reset, synchronous and active-high.
REQ-007 pndng  input  [bits-1:0][drvrs-1:0]  driver d holds at least one packet.
REQ-008 D_pop  input  [bits-1:0][drvrs-1:0][pckg_sz-1:0]  head packet of driver d; valid whenever pndng is high (show-ahead FIFO).
REQ-009 pop  output  [bits-1:0][drvrs-1:0]  one-cycle strobe that consumes the head packet of driver d.
REQ-010 push  output  [bits-1:0][drvrs-1:0]  one-cycle strobe that writes D_push into receiver d.
REQ-011 D_push  output  [bits-1:0][drvrs-1:0][pckg_sz-1:0]  packet presented to receiver d.
REQ-012 Port names and packed layout SHALL match the signals of dut_compl_if; per-driver fifo_if_out signals (pndg, pop, dpop) map to index [0][d].

Function
REQ-013 Packet format: the destination ID is bits [pckg_sz-1 -: 8]; the payload is the remaining bits, which are carried unchanged.
REQ-014 FSM has two states, ARB and DLVR.
REQ-015 ARB: if any pndng bit is set, grant g SHALL be the first set bit searching round-robin from last_grant+1 (modulo drvrs); the block asserts registered pop[0][g] for exactly one cycle, latches D_pop[0][g] and source = g, and goes to DLVR.
REQ-016 ARB with no pndng set: all pop and push bits stay 0 and the FSM stays in ARB.
REQ-017 DLVR, unicast (ID < drvrs): assert push[0][ID] for one cycle, including when ID equals source.
REQ-018 DLVR, broadcast (ID == broadcast): assert push[0][d] for every d != source in the same cycle.
REQ-019 DLVR, invalid ID (>= drvrs and not broadcast): the packet is dropped and no push is asserted.
REQ-020 On leaving DLVR, last_grant is set to source and the FSM returns to ARB.
REQ-021 Every D_push[0][d] carries the latched packet; the value is held between transfers.
REQ-022 Timing: pop occurs in cycle N and push in cycle N+1; throughput is one packet per 2 cycles; pop and push are never both high in the same cycle.
REQ-023 With all drivers pending, grants rotate 0,1,2,... (fairness); no driver waits more than drvrs transfers.
REQ-024 A pndng change during DLVR has no effect until the next ARB cycle.

Reset
REQ-025 While reset is high at a clock edge: pop=0, push=0, D_push=0, FSM=ARB, last_grant=drvrs-1 (driver 0 has first priority).
REQ-026 Reset asserted mid-transfer SHALL abort the transfer with no push; the popped packet is lost.
REQ-027 The first pop is possible in the cycle after reset deasserts.

Structure
REQ-028 Shared package bs_pkg SHALL hold ID_W=8, the default broadcast value, and the FSM state enum.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: req[drvrs], last_grant; outputs: grant index, valid).
REQ-030 All outputs SHALL be registered.

Verification
REQ-031 drvrs=8, pckg_sz=16; driver 2 pending with 16'h05AB -> pop[2] in cycle N; push[5] with D_push=16'h05AB in cycle N+1; no other push.
REQ-032 Driver 3 sends 16'hFF12 -> push bits 0-2 and 4-7 high in one cycle with D_push=16'hFF12; push[3]=0.
REQ-033 Driver 1 sends 16'h0900 -> pop[1] pulses and no push is asserted.
REQ-034 All 8 drivers held pending -> pop order is 0,1,...,7,0 with pops spaced 2 cycles apart.
REQ-035 Reset raised in the DLVR cycle -> no push occurs, and all outputs read 0 on the next edge.
REQ-036 Driver 4 sends 16'h04AA -> push[4] with 16'h04AA (self-delivery).
